// File: rtl/tick_period_checker.sv
// Period and health monitor for a single-cycle periodic tick: acquires lock after
// C_LOCK_COUNT correct intervals, then flags and counts early or missing ticks.
module tick_period_checker #(
  parameter int C_NUM_CYCLES = 255,
  parameter int C_LOCK_COUNT = 3,
  localparam int PW = $clog2(C_NUM_CYCLES + 1)
) (
  input  logic          ck_i,
  input  logic          rst_n_i,
  input  logic          tick_i,
  input  logic          err_clr_i,
  output logic          locked_o,
  output logic          err_o,
  output logic [7:0]    err_cnt_o,
  output logic [PW-1:0] phase_o
);

  localparam int GW = $clog2(C_LOCK_COUNT + 1);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          locked_q;

  logic          full;
  logic [PW-1:0] cnt_inc;

  assign full    = (cnt_q == PW'(C_NUM_CYCLES));
  assign cnt_inc = full ? cnt_q : cnt_q + PW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      S_SEARCH: begin
        cnt_d = '0;
        if (tick_i) begin
          state_d = S_ACQUIRE;
          good_d  = '0;
          cnt_d   = PW'(1);
        end
      end
      S_ACQUIRE: begin
        if (tick_i) begin
          cnt_d = PW'(1);
          if (full) begin
            if (32'(good_q) + 32'd1 == C_LOCK_COUNT) begin
              state_d = S_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            // Early tick restarts the qualification from this tick.
            good_d = '0;
          end
        end else if (full) begin
          state_d = S_SEARCH;
          good_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOCKED: begin
        if (tick_i) begin
          cnt_d = PW'(1);
          if (!full) begin
            err_d   = 1'b1;
            state_d = S_ACQUIRE;
            good_d  = '0;
          end
        end else if (full) begin
          err_d   = 1'b1;
          state_d = S_SEARCH;
          good_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_SEARCH;
        cnt_d   = '0;
        good_d  = '0;
      end
    endcase
  end

  // Clear takes priority over a coincident increment; the ERR pulse is unaffected.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ck_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_SEARCH;
      cnt_q     <= '0;
      good_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= (state_d == S_LOCKED);
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign phase_o   = cnt_q;

endmodule

// File: tb/tb_tick_period_checker.sv
// Scoreboard bench for tick_period_checker: a timestamp-based reference model
// predicts every cycle's outputs; a separate monitor pops and compares.
module tb_tick_period_checker;

  localparam int N = 8;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [3:0] phase;

  always #5 clk = ~clk;

  tick_period_checker #(
    .C_NUM_CYCLES(N),
    .C_LOCK_COUNT(L)
  ) dut (
    .ck_i     (clk),
    .rst_n_i  (rst_n),
    .tick_i   (tick),
    .err_clr_i(clr),
    .locked_o (locked),
    .err_o    (err),
    .err_cnt_o(err_cnt),
    .phase_o  (phase)
  );

  typedef struct {
    int locked;
    int err;
    int cnt;
    int phase;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: 0 = searching, 1 = acquiring, 2 = locked.
  // Time is counted in sampling edges; m_last is the edge of the last accepted tick.
  int m_mode, m_good, m_errs, m_now, m_last;

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_errs = 0; m_now = 0; m_last = 0;
  endtask

  task automatic model_step(input bit t, input bit c);
    exp_t e;
    int el;
    bit e_err;
    e_err = 1'b0;
    m_now++;
    el = m_now - m_last;
    if (m_mode == 0) begin
      if (t) begin
        m_mode = 1; m_last = m_now; m_good = 0;
      end
    end else if (t) begin
      if (el == N) begin
        if (m_mode == 1) begin
          m_good++;
          if (m_good == L) begin
            m_mode = 2; m_good = 0;
          end
        end
      end else begin
        if (m_mode == 2) e_err = 1'b1;
        m_mode = 1; m_good = 0;
      end
      m_last = m_now;
    end else if (el >= N) begin
      if (m_mode == 2) e_err = 1'b1;
      m_mode = 0; m_good = 0;
    end
    if (c) m_errs = 0;
    else if (e_err && m_errs < 255) m_errs++;
    e.locked = (m_mode == 2) ? 1 : 0;
    e.err    = e_err ? 1 : 0;
    e.cnt    = m_errs;
    if (m_mode == 0) e.phase = 0;
    else e.phase = (m_now - m_last + 1 > N) ? N : (m_now - m_last + 1);
    sb.push_back(e);
  endtask

  task automatic cycle(input bit t, input bit c);
    @(negedge clk);
    tick = t;
    clr  = c;
    model_step(t, c);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0);
  endtask

  task automatic tick_after(input int gap, input bit c);
    idle(gap - 1);
    cycle(1'b1, c);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0 || phase !== 4'd0) begin
      failures++;
      $display("FAIL %s: locked/err/err_cnt/phase got %0d/%0d/%0d/%0d, required 0/0/0/0",
               name, locked, err, err_cnt, phase);
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero(name);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_up();
    cycle(1'b1, 1'b0);
    repeat (L) tick_after(N, 1'b0);
  endtask

  // Monitor: every cycle with a pending prediction is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(locked) != e.locked || int'(err) != e.err ||
            int'(err_cnt) != e.cnt || int'(phase) != e.phase) begin
          failures++;
          $display("FAIL cyc %0d outputs: locked/err/err_cnt/phase got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                   cyc, locked, err, err_cnt, phase, e.locked, e.err, e.cnt, e.phase);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, r;
    model_reset();
    #1;
    rst_n = 1'b0;
    #2;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    $display("scenario: acquire");
    idle(4);
    lock_up();
    idle(3);

    $display("scenario: early tick and relock");
    tick_after(N - 5, 1'b0);
    tick_after(N - 2, 1'b0);
    repeat (L) tick_after(N, 1'b0);

    $display("scenario: missing tick");
    idle(20);
    tick_after(1, 1'b0);
    repeat (L) tick_after(N, 1'b0);

    $display("scenario: saturation and clear");
    repeat (300) begin
      tick_after(N - 2, 1'b0);
      repeat (L) tick_after(N, 1'b0);
    end
    tick_after(N - 2, 1'b1);
    idle(2);

    $display("scenario: async reset while locked");
    do_reset("reset_clean");
    idle(2);
    lock_up();
    repeat (5) begin
      tick_after(N - 3, 1'b0);
      repeat (L) tick_after(N, 1'b0);
    end
    idle(2);
    do_reset("reset_locked_mid_cycle");
    idle(3);

    $display("scenario: stuck-high tick");
    repeat (100) cycle(1'b1, 1'b0);
    idle(12);

    $display("scenario: random periods");
    lock_up();
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r < 6) gap = N;
      else if (r < 8) gap = $urandom_range(1, N - 1);
      else gap = $urandom_range(N + 1, N + 6);
      tick_after(gap, ($urandom_range(0, 15) == 0));
    end
    idle(3);

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending predictions got %0d, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
